monochrome_ctrl: RTL and testbench
==================================

// Module: monochrome_ctrl
// PURPOSE
//  Owns the 2-bit monochrome mode driven into the colour-path monochrome stage
//  (00 colour, 01 green, 10 amber, 11 B/W). Accepts mode requests from a ZX-UNO
//  register and a keyboard hotkey, and defers each change to the next vertical sync.
//  Optionally blanks video for whole frames around the switch.
//  Sits between zxuno register bus/keyboard and the video output stage.
// PARAMETERS
//  MONOADDR      8'hFB      zxuno register address of the mode register
//  BLANK_FRAMES  1          frames of forced blank after a switch (0 = none, max 15)
//  VS_TIMEOUT    1000000    clk cycles to wait for vsync before forcing the change
// PORTS
//  clk                  in   1  system clock
//  rst                  in   1  asynchronous reset, active high
//  zxuno_addr           in   8  register address
//  zxuno_regrd          in   1  register read strobe
//  zxuno_regwr          in   1  register write strobe, one-cycle pulse
//  din                  in   8  write data
//  dout                 out  8  read data
//  oe_n                 out  1  low while MONOADDR is being read
//  hotkey_cycle         in   1  asynchronous level from keyboard; rising edge cycles mode
//  vsync                in   1  asynchronous vertical sync, active high
//  monochrome_selection out  2  applied mode to the monochrome stage
//  blank                out  1  force video to black
//  pending              out  1  request accepted, not yet applied
// BEHAVIOUR
//  Reset: monochrome_selection=00, req=00, lock=0, immed=0, blank=0, pending=0.
//   Also on reset: dout=8'hFF, oe_n=1, FSM=IDLE, counters=0.
//  Reset mid-switch discards the request and returns to colour mode immediately.
//  Register write (addr==MONOADDR & regwr): req<=din[1:0], lock<=din[7], immed<=din[6].
//  Register read: dout={lock,immed,pending,blank,monochrome_selection,req}; oe_n=0
//   combinationally while addr==MONOADDR & regrd; otherwise dout=8'hFF, oe_n=1.
//  hotkey_cycle and vsync each pass a 2-FF synchroniser plus a rising-edge detector.
//   The resulting edge pulse is 3 clk after the input edge.
//  Hotkey edge with lock=0: req<=req+1, wrapping 11->00. With lock=1 it is ignored.
//  Write and hotkey edge in the same cycle: the write wins and the hotkey is dropped.
//  FSM:
//   IDLE:    if req!=applied: immed=1 -> APPLY next clk; else -> WAIT_VS and clear tcnt.
//   WAIT_VS: pending=1 and tcnt increments.
//            If req==applied (request cancelled) -> IDLE and pending=0.
//            Vsync edge, or tcnt==VS_TIMEOUT-1 -> APPLY.
//   APPLY:   one cycle. monochrome_selection<=req; pending<=0.
//            BLANK_FRAMES>0: blank<=1, fcnt<=BLANK_FRAMES -> BLANK.
//            Otherwise -> IDLE.
//   BLANK:   each vsync edge decrements fcnt.
//            When fcnt hits 0: blank<=0 -> IDLE, taking effect on that same edge.
//  req is sampled in APPLY. Writes and hotkeys accepted during APPLY/BLANK only update req;
//   they are re-evaluated in IDLE.
//  Vsync edge and timeout in the same cycle count once.
//  Only the vsync edge path decrements fcnt; the timeout does not.
//  If a vsync edge coincides with APPLY, that edge is not counted as a blank frame.
//  Change latency, immed=1: 2 clk from write to output.
//  Change latency, immed=0: next synchronised vsync edge + 1 clk.
//  All outputs except dout/oe_n are registered.
// STRUCTURE
//  Package monochrome_pkg: mode constants MONO_COLOUR/GREEN/AMBER/BW (2'b00..2'b11).
//   Also holds register bit positions LOCK_BIT=7 and IMMED_BIT=6, and the FSM state encodings.
//  Sub-module sync_edge: 2-FF synchroniser + rising-edge pulse.
//   Instantiated twice, for hotkey_cycle and vsync.
//  tcnt width: $clog2(VS_TIMEOUT). fcnt: 4 bits.
// TESTING
//  Reset, then write 8'h01 with immed=0. Mode must stay 00 and pending=1;
//   on the first vsync pulse it becomes 01 exactly 4 clk after the vsync rise.
//  Write 8'h43 (immed, mode 11). Output is 11 two clk after the write; vsync is never pulsed.
//  BLANK_FRAMES=2, switch to 10. blank=1 from APPLY through two further vsync edges.
//   blank=0 and state IDLE on the second edge.
//  Four hotkey edges with lock=0: req sequence 01,10,11,00.
//   Write 8'h80, then hotkey: req unchanged.
//  Write 8'h02, then write 8'h00 before any vsync. pending drops, mode remains 00,
//   and the next vsync causes no change or blank.
//  VS_TIMEOUT=100, no vsync, write 8'h01. Mode becomes 01 at the 100th cycle of WAIT_VS.
//  Assert rst during BLANK. All outputs return to reset values asynchronously.

Source files
------------

// File: rtl/monochrome_pkg.sv
// Shared constants for the monochrome mode controller: mode codes, register bit
// positions and FSM state encodings.
package monochrome_pkg;

    localparam logic [1:0] MONO_COLOUR = 2'b00;
    localparam logic [1:0] MONO_GREEN  = 2'b01;
    localparam logic [1:0] MONO_AMBER  = 2'b10;
    localparam logic [1:0] MONO_BW     = 2'b11;

    localparam int LOCK_BIT  = 7;
    localparam int IMMED_BIT = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_APPLY   = 2'd2,
        ST_BLANK   = 2'd3
    } mono_state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detector.
// o_pulse is high for one clk, during the cycle before the third clk edge after the input rises.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_pulse
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_pulse = r_s2 & ~r_s3;

endmodule

// File: rtl/monochrome_ctrl.sv
// Holds the applied monochrome mode, accepts register/hotkey requests and defers
// each change to the next vsync (or timeout), optionally blanking whole frames after it.
module monochrome_ctrl
    import monochrome_pkg::*;
#(
    parameter logic [7:0] MONOADDR     = 8'hFB,
    parameter int         BLANK_FRAMES = 1,
    parameter int         VS_TIMEOUT   = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] zxuno_addr,
    input  logic       zxuno_regrd,
    input  logic       zxuno_regwr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       oe_n,
    input  logic       hotkey_cycle,
    input  logic       vsync,
    output logic [1:0] monochrome_selection,
    output logic       blank,
    output logic       pending
);

    localparam int              TW         = (VS_TIMEOUT > 1) ? $clog2(VS_TIMEOUT) : 1;
    localparam logic [TW-1:0]   TLAST      = TW'(VS_TIMEOUT - 1);
    localparam logic [3:0]      BLANK_INIT = 4'(BLANK_FRAMES);

    logic          w_hk;
    logic          w_vs;
    logic          w_wr;
    logic          w_unused_din;

    logic [1:0]    r_req;
    logic          r_lock;
    logic          r_immed;
    logic [1:0]    r_mode;
    logic          r_blank;
    logic          r_pend;
    logic [TW-1:0] r_tcnt;
    logic [3:0]    r_fcnt;
    mono_state_t   r_state;

    mono_state_t   w_state_nxt;
    logic [1:0]    w_mode_nxt;
    logic          w_blank_nxt;
    logic          w_pend_nxt;
    logic [TW-1:0] w_tcnt_nxt;
    logic [3:0]    w_fcnt_nxt;

    sync_edge u_hk_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (hotkey_cycle),
        .o_pulse (w_hk)
    );

    sync_edge u_vs_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (vsync),
        .o_pulse (w_vs)
    );

    assign w_wr         = zxuno_regwr && (zxuno_addr == MONOADDR);
    assign w_unused_din = ^din[5:2];

    // A register write in the same cycle as a hotkey edge swallows the hotkey.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req   <= MONO_COLOUR;
            r_lock  <= 1'b0;
            r_immed <= 1'b0;
        end else if (w_wr) begin
            r_req   <= din[1:0];
            r_lock  <= din[LOCK_BIT];
            r_immed <= din[IMMED_BIT];
        end else if (w_hk && !r_lock) begin
            r_req   <= r_req + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_mode  <= MONO_COLOUR;
            r_blank <= 1'b0;
            r_pend  <= 1'b0;
            r_tcnt  <= '0;
            r_fcnt  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_blank <= w_blank_nxt;
            r_pend  <= w_pend_nxt;
            r_tcnt  <= w_tcnt_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_blank_nxt = r_blank;
        w_pend_nxt  = r_pend;
        w_tcnt_nxt  = r_tcnt;
        w_fcnt_nxt  = r_fcnt;
        case (r_state)
            ST_IDLE: begin
                if (r_req != r_mode) begin
                    if (r_immed) begin
                        w_state_nxt = ST_APPLY;
                    end else begin
                        w_state_nxt = ST_WAIT_VS;
                        w_tcnt_nxt  = '0;
                        w_pend_nxt  = 1'b1;
                    end
                end
            end
            ST_WAIT_VS: begin
                if (r_req == r_mode) begin
                    w_state_nxt = ST_IDLE;
                    w_pend_nxt  = 1'b0;
                end else if (w_vs || (r_tcnt == TLAST)) begin
                    w_state_nxt = ST_APPLY;
                end else begin
                    w_tcnt_nxt  = r_tcnt + TW'(1);
                end
            end
            // A vsync edge landing in this cycle is deliberately not counted as a blank frame.
            ST_APPLY: begin
                w_mode_nxt = r_req;
                w_pend_nxt = 1'b0;
                if (BLANK_FRAMES > 0) begin
                    w_blank_nxt = 1'b1;
                    w_fcnt_nxt  = BLANK_INIT;
                    w_state_nxt = ST_BLANK;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BLANK: begin
                if (w_vs) begin
                    if (r_fcnt <= 4'd1) begin
                        w_fcnt_nxt  = 4'd0;
                        w_blank_nxt = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_fcnt_nxt  = r_fcnt - 4'd1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        dout = 8'hFF;
        oe_n = 1'b1;
        if ((zxuno_addr == MONOADDR) && zxuno_regrd) begin
            dout = {r_lock, r_immed, r_pend, r_blank, r_mode, r_req};
            oe_n = 1'b0;
        end
    end

    assign monochrome_selection = r_mode;
    assign blank                = r_blank;
    assign pending              = r_pend;

endmodule

// File: tb/tb_monochrome_ctrl.sv
// Directed bench for monochrome_ctrl built with BLANK_FRAMES=2, VS_TIMEOUT=100.
module tb_monochrome_ctrl;

    localparam logic [7:0] ADDR = 8'hFB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] zxuno_addr = 8'h00;
    logic       zxuno_regrd = 1'b0;
    logic       zxuno_regwr = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       oe_n;
    logic       hotkey_cycle = 1'b0;
    logic       vsync = 1'b0;
    logic [1:0] monochrome_selection;
    logic       blank;
    logic       pending;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] rv;

    monochrome_ctrl #(
        .MONOADDR     (ADDR),
        .BLANK_FRAMES (2),
        .VS_TIMEOUT   (100)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .zxuno_addr           (zxuno_addr),
        .zxuno_regrd          (zxuno_regrd),
        .zxuno_regwr          (zxuno_regwr),
        .din                  (din),
        .dout                 (dout),
        .oe_n                 (oe_n),
        .hotkey_cycle         (hotkey_cycle),
        .vsync                (vsync),
        .monochrome_selection (monochrome_selection),
        .blank                (blank),
        .pending              (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    // Leaves the bench 1ns after the n-th rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        zxuno_addr  = ADDR;
        din         = d;
        zxuno_regwr = 1'b1;
        tick(1);
        zxuno_regwr = 1'b0;
    endtask

    task automatic rd(output logic [7:0] v);
        zxuno_addr  = ADDR;
        zxuno_regrd = 1'b1;
        #1;
        v = dout;
        zxuno_regrd = 1'b0;
        #1;
    endtask

    task automatic hk_pulse();
        hotkey_cycle = 1'b1;
        tick(3);
        hotkey_cycle = 1'b0;
        tick(3);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        #1 rst = 1'b1;
        tick(2);
        chk("rst_mode", {6'd0, monochrome_selection}, 8'h00);
        chk("rst_blank", {7'd0, blank}, 8'h00);
        chk("rst_pending", {7'd0, pending}, 8'h00);
        chk("rst_dout", dout, 8'hFF);
        chk("rst_oe_n", {7'd0, oe_n}, 8'h01);
        rst = 1'b0;
        tick(1);

        // Deferred change to green, then two blank frames.
        wr(8'h01);
        tick(2);
        chk("defer_pending", {7'd0, pending}, 8'h01);
        chk("defer_mode_hold", {6'd0, monochrome_selection}, 8'h00);
        vsync = 1'b1;
        tick(3);
        chk("defer_mode_e3", {6'd0, monochrome_selection}, 8'h00);
        tick(1);
        chk("defer_mode_e4", {6'd0, monochrome_selection}, 8'h01);
        chk("defer_blank_on", {7'd0, blank}, 8'h01);
        chk("defer_pending_clr", {7'd0, pending}, 8'h00);
        vsync = 1'b0;
        tick(3);
        vsync = 1'b1;
        tick(3);
        chk("blank_frame1", {7'd0, blank}, 8'h01);
        vsync = 1'b0;
        tick(3);
        vsync = 1'b1;
        tick(2);
        chk("blank_frame2_pre", {7'd0, blank}, 8'h01);
        tick(1);
        chk("blank_frame2_off", {7'd0, blank}, 8'h00);
        vsync = 1'b0;
        tick(3);
        rd(rv);
        chk("idle_regread", rv, 8'h05);
        zxuno_addr  = 8'hFA;
        zxuno_regrd = 1'b1;
        #1;
        chk("other_addr_dout", dout, 8'hFF);
        chk("other_addr_oe_n", {7'd0, oe_n}, 8'h01);
        zxuno_regrd = 1'b0;

        // Hotkey cycling from colour.
        do_reset();
        hk_pulse(); rd(rv); chk("hk_req1", {6'd0, rv[1:0]}, 8'h01);
        hk_pulse(); rd(rv); chk("hk_req2", {6'd0, rv[1:0]}, 8'h02);
        hk_pulse(); rd(rv); chk("hk_req3", {6'd0, rv[1:0]}, 8'h03);
        hk_pulse(); rd(rv); chk("hk_req0", {6'd0, rv[1:0]}, 8'h00);
        chk("hk_pending_cancel", {7'd0, pending}, 8'h00);
        chk("hk_mode", {6'd0, monochrome_selection}, 8'h00);
        wr(8'h80);
        hk_pulse();
        rd(rv);
        chk("hk_locked", rv, 8'h80);

        // Write lands on the same edge as the hotkey pulse.
        wr(8'h00);
        hotkey_cycle = 1'b1;
        tick(2);
        wr(8'h00);
        hotkey_cycle = 1'b0;
        tick(3);
        rd(rv);
        chk("wr_beats_hk", {6'd0, rv[1:0]}, 8'h00);

        // Request cancelled before vsync.
        wr(8'h02);
        tick(1);
        chk("cancel_pending_set", {7'd0, pending}, 8'h01);
        wr(8'h00);
        tick(1);
        chk("cancel_pending_clr", {7'd0, pending}, 8'h00);
        vsync = 1'b1;
        tick(3);
        vsync = 1'b0;
        tick(3);
        chk("cancel_mode", {6'd0, monochrome_selection}, 8'h00);
        chk("cancel_blank", {7'd0, blank}, 8'h00);

        // Vsync timeout.
        wr(8'h01);
        tick(101);
        chk("to_mode_before", {6'd0, monochrome_selection}, 8'h00);
        chk("to_pending_before", {7'd0, pending}, 8'h01);
        tick(1);
        chk("to_mode_after", {6'd0, monochrome_selection}, 8'h01);
        chk("to_blank_after", {7'd0, blank}, 8'h01);

        // Immediate change, then asynchronous reset during the blank.
        do_reset();
        wr(8'h43);
        chk("imm_mode_w0", {6'd0, monochrome_selection}, 8'h00);
        tick(1);
        chk("imm_mode_w1", {6'd0, monochrome_selection}, 8'h00);
        tick(1);
        chk("imm_mode_w2", {6'd0, monochrome_selection}, 8'h03);
        rd(rv);
        chk("imm_regread", rv, 8'h5F);
        #1 rst = 1'b1;
        #1;
        chk("arst_mode", {6'd0, monochrome_selection}, 8'h00);
        chk("arst_blank", {7'd0, blank}, 8'h00);
        chk("arst_pending", {7'd0, pending}, 8'h00);
        chk("arst_dout", dout, 8'hFF);
        chk("arst_oe_n", {7'd0, oe_n}, 8'h01);
        tick(1);
        rst = 1'b0;
        tick(1);
        rd(rv);
        chk("arst_regread", rv, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
